// File: rtl/btb_train_queue_pkg.sv
// Shared constants for the BTB training queue: the BTB's active-low strobe
// encodings, the default queue depth and the storage entry layout.
package btb_train_queue_pkg;

  // BTB commit inputs are active low.
  localparam logic ENABLE_N  = 1'b0;
  localparam logic DISABLE_N = 1'b1;

  localparam int BTB_TRAIN_DEPTH = 8;

  // Entry layout, MSB first: {taken, pc, tar}.
  function automatic int btb_train_entry_width(input int addr);
    return 1 + 2 * addr;
  endfunction

endpackage

// File: rtl/btb_train_queue.sv
// Buffers resolved branches between execute and commit. Retired entries are
// replayed onto the BTB training port in program order, one per cycle.
module btb_train_queue
  import btb_train_queue_pkg::*;
#(
  parameter int ADDR  = 32,
  parameter int DEPTH = BTB_TRAIN_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       br_valid,
  input  logic                       br_taken,
  input  logic [ADDR-1:0]            br_pc,
  input  logic [ADDR-1:0]            br_tar,
  output logic                       br_ready,
  input  logic                       br_commit,
  input  logic                       flush,
  output logic                       pc_chg_com_,
  output logic                       chg_taken_,
  output logic [ADDR-1:0]            com_addr,
  output logic [ADDR-1:0]            com_tar_addr,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       commit_err
);

  localparam int PTR = $clog2(DEPTH);
  localparam int EW  = btb_train_entry_width(ADDR);
  localparam logic [PTR:0] PTR_ONE = {{PTR{1'b0}}, 1'b1};

  // Handshake: a branch is accepted on any cycle with br_valid & br_ready
  // and no flush; br_ready depends only on registered pointers.

  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   mem_d [DEPTH];
  logic [PTR:0]    head_q, head_d;
  logic [PTR:0]    cptr_q, cptr_d;
  logic [PTR:0]    tail_q, tail_d;
  logic            strobe_n_q, strobe_n_d;
  logic            taken_n_q, taken_n_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [ADDR-1:0] tar_q, tar_d;
  logic            err_q, err_d;

  logic            full;
  logic            enq;
  logic            commit_ok;
  logic            drain;
  logic [EW-1:0]   head_entry;

  // Full: same slot index, opposite wrap bit.
  assign full       = (tail_q[PTR-1:0] == head_q[PTR-1:0]) && (tail_q[PTR] != head_q[PTR]);
  assign br_ready   = ~full;
  assign occupancy  = tail_q - head_q;
  assign head_entry = mem_q[head_q[PTR-1:0]];

  always_comb begin
    enq       = br_valid & ~full & ~flush;
    commit_ok = br_commit & (cptr_q != tail_q);
    drain     = (head_q != cptr_q);

    head_d = drain ? head_q + PTR_ONE : head_q;
    cptr_d = commit_ok ? cptr_q + PTR_ONE : cptr_q;
    // Flush keeps committed entries (including one committed this cycle).
    if (flush) begin
      tail_d = cptr_d;
    end else if (enq) begin
      tail_d = tail_q + PTR_ONE;
    end else begin
      tail_d = tail_q;
    end

    err_d = err_q | (br_commit & ~commit_ok);

    mem_d = mem_q;
    if (enq) begin
      mem_d[tail_q[PTR-1:0]] = {br_taken, br_pc, br_tar};
    end
  end

  always_comb begin
    strobe_n_d = DISABLE_N;
    taken_n_d  = DISABLE_N;
    addr_d     = '0;
    tar_d      = '0;
    if (drain) begin
      strobe_n_d = ENABLE_N;
      taken_n_d  = head_entry[EW-1] ? ENABLE_N : DISABLE_N;
      addr_d     = head_entry[EW-2:ADDR];
      tar_d      = head_entry[ADDR-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      cptr_q     <= '0;
      tail_q     <= '0;
      strobe_n_q <= DISABLE_N;
      taken_n_q  <= DISABLE_N;
      addr_q     <= '0;
      tar_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      cptr_q     <= cptr_d;
      tail_q     <= tail_d;
      strobe_n_q <= strobe_n_d;
      taken_n_q  <= taken_n_d;
      addr_q     <= addr_d;
      tar_q      <= tar_d;
      err_q      <= err_d;
    end
  end

  // Storage contents need no reset; pointers define what is live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign pc_chg_com_  = strobe_n_q;
  assign chg_taken_   = taken_n_q;
  assign com_addr     = addr_q;
  assign com_tar_addr = tar_q;
  assign commit_err   = err_q;

endmodule

// File: tb/tb_btb_train_queue.sv
// Directed bench for btb_train_queue: a queue-level model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_btb_train_queue;

  localparam int ADDR  = 32;
  localparam int DEPTH = 8;
  localparam int PTR   = $clog2(DEPTH);

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            reset;
  logic            br_valid, br_taken, br_commit, flush;
  logic [ADDR-1:0] br_pc, br_tar;
  logic            br_ready;
  logic            pc_chg_com_, chg_taken_;
  logic [ADDR-1:0] com_addr, com_tar_addr;
  logic [PTR:0]    occupancy;
  logic            commit_err;

  always #5 clk = ~clk;

  btb_train_queue #(.ADDR(ADDR), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .br_valid     (br_valid),
    .br_taken     (br_taken),
    .br_pc        (br_pc),
    .br_tar       (br_tar),
    .br_ready     (br_ready),
    .br_commit    (br_commit),
    .flush        (flush),
    .pc_chg_com_  (pc_chg_com_),
    .chg_taken_   (chg_taken_),
    .com_addr     (com_addr),
    .com_tar_addr (com_tar_addr),
    .occupancy    (occupancy),
    .commit_err   (commit_err)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;
  logic [ADDR-1:0] seen_q[$];
  logic [ADDR-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The queue is a list of branches oldest first; the first m_ncom are retired.
  typedef struct {
    logic            taken;
    logic [ADDR-1:0] pc;
    logic [ADDR-1:0] tar;
  } ent_t;

  ent_t            m_q[$];
  int              m_ncom = 0;
  logic            m_live = 1'b0;
  logic            exp_strobe_n, exp_taken_n, exp_err;
  logic [ADDR-1:0] exp_addr, exp_tar;
  logic            m_ready, m_drain, m_cok;
  ent_t            m_new;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_ncom       = 0;
      exp_strobe_n = 1'b1;
      exp_taken_n  = 1'b1;
      exp_addr     = '0;
      exp_tar      = '0;
      exp_err      = 1'b0;
      m_live       = 1'b1;
    end else if (m_live) begin
      m_ready = (m_q.size() < DEPTH);
      m_drain = (m_ncom > 0);
      m_cok   = br_commit && (m_ncom < m_q.size());
      if (m_drain) begin
        exp_strobe_n = 1'b0;
        exp_taken_n  = ~m_q[0].taken;
        exp_addr     = m_q[0].pc;
        exp_tar      = m_q[0].tar;
        void'(m_q.pop_front());
        m_ncom--;
      end else begin
        exp_strobe_n = 1'b1;
        exp_taken_n  = 1'b1;
        exp_addr     = '0;
        exp_tar      = '0;
      end
      if (br_commit && !m_cok) exp_err = 1'b1;
      if (m_cok) m_ncom++;
      if (flush) begin
        while (m_q.size() > m_ncom) void'(m_q.pop_back());
      end else if (br_valid && m_ready) begin
        m_new.taken = br_taken;
        m_new.pc    = br_pc;
        m_new.tar   = br_tar;
        m_q.push_back(m_new);
      end
    end
  end

  // ---------------- compare process + strobe monitor ----------------
  always @(negedge clk) begin
    if (m_live) begin
      chk("strobe",    pc_chg_com_,  exp_strobe_n);
      chk("taken_n",   chg_taken_,   exp_taken_n);
      chk("com_addr",  com_addr,     exp_addr);
      chk("com_tar",   com_tar_addr, exp_tar);
      chk("err",       commit_err,   exp_err);
      chk("occupancy", occupancy,    m_q.size());
      chk("br_ready",  br_ready,     m_q.size() < DEPTH);
    end
    if (pc_chg_com_ === 1'b0) begin
      strobe_cnt++;
      seen_q.push_back(com_addr);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic t, input logic [ADDR-1:0] pc,
                       input logic [ADDR-1:0] tar, input logic c, input logic f);
    br_valid  = v;
    br_taken  = t;
    br_pc     = pc;
    br_tar    = tar;
    br_commit = c;
    flush     = f;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    chk("rst_occ",    occupancy,   0);
    chk("rst_ready",  br_ready,    1);
    chk("rst_strobe", pc_chg_com_, 1);
    chk("rst_taken",  chg_taken_,  1);
    chk("rst_err",    commit_err,  0);
    reset = 1'b0;

    // Basic train: enqueue cycle 0, commit cycle 1, strobe in cycle 3.
    drive(1'b1, 1'b1, 32'hdeadbe74, 32'hcafecafe, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    chk("basic_strobe",  pc_chg_com_,  0);
    chk("basic_taken",   chg_taken_,   0);
    chk("basic_addr",    com_addr,     32'hdeadbe74);
    chk("basic_tar",     com_tar_addr, 32'hcafecafe);
    tick();
    chk("basic_one_strobe", pc_chg_com_, 1);
    chk("basic_count",      strobe_cnt,  1);

    // Flush with a same-cycle commit: occupancy 3 -> 1 -> 0, one strobe.
    seen_q.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i[0], 32'h100 + 32'(4 * i), 32'h900 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    chk("flush_occ3", occupancy, 3);
    drive(1'b1, 1'b0, 32'hbad0, 32'hbad0, 1'b1, 1'b1);
    tick();
    chk("flush_occ1", occupancy, 1);
    idle();
    tick();
    chk("flush_occ0", occupancy, 0);
    drive(1'b1, 1'b1, 32'h10c, 32'h91c, 1'b0, 1'b0);
    tick();
    chk("flush_reenq_occ", occupancy, 1);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    tick();
    chk("flush_strobes", seen_q.size(), 2);
    if (seen_q.size() == 2) begin
      chk("flush_pc0", seen_q[0], 32'h100);
      chk("flush_pc1", seen_q[1], 32'h10c);
    end

    // Full: eight entries, a ninth ignored, then eight commits drain in order.
    seen_q.delete();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b1, 32'h2000 + 32'(4 * i), 32'h7000 + 32'(i), 1'b0, 1'b0);
      exp_q.push_back(32'h2000 + 32'(4 * i));
      tick();
    end
    chk("full_ready", br_ready,  0);
    chk("full_occ",   occupancy, 8);
    drive(1'b1, 1'b0, 32'hbad, 32'hbad, 1'b0, 1'b0);
    tick();
    chk("full_ninth_occ", occupancy, 8);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      tick();
    end
    idle();
    tick();
    tick();
    chk("full_occ_end", occupancy, 0);
    chk("full_strobes", seen_q.size(), exp_q.size());
    for (int i = 0; i < DEPTH; i++) begin
      if (i < seen_q.size()) chk("full_order", seen_q[i], exp_q[i]);
    end

    // Simultaneous commit + flush with two uncommitted entries.
    seen_q.delete();
    drive(1'b1, 1'b0, 32'h3000, 32'h3100, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'h3004, 32'h3104, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    tick();
    chk("sim_occ1", occupancy, 1);
    idle();
    tick();
    chk("sim_taken", chg_taken_, 1);
    tick();
    tick();
    chk("sim_strobes", seen_q.size(), 1);
    if (seen_q.size() == 1) chk("sim_pc", seen_q[0], 32'h3000);
    chk("sim_occ0", occupancy, 0);

    // Commit on an empty queue: sticky error, no strobe.
    seen_q.delete();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    idle();
    chk("err_set", commit_err, 1);
    tick();
    tick();
    chk("err_sticky",    commit_err,    1);
    chk("err_no_strobe", seen_q.size(), 0);

    // Reset while committed entries are pending: nothing trains afterwards.
    drive(1'b1, 1'b1, 32'h4000, 32'h4100, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'h4004, 32'h4104, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    seen_q.delete();
    for (int i = 0; i < 4; i++) tick();
    chk("rst2_no_strobe", seen_q.size(), 0);
    chk("rst2_strobe",    pc_chg_com_,   1);
    chk("rst2_taken",     chg_taken_,    1);
    chk("rst2_addr",      com_addr,      0);
    chk("rst2_tar",       com_tar_addr,  0);
    chk("rst2_occ",       occupancy,     0);
    chk("rst2_ready",     br_ready,      1);
    chk("rst2_err",       commit_err,    0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
